// File: rtl/st_decoder_pkg.sv
// ---------------------------------------------------------------------------
// st_decoder_pkg
// Decoder-private types: FSM state encoding and a beat-length helper.
// ---------------------------------------------------------------------------
package st_decoder_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        W7   = 3'd1,
        W8   = 3'd2,
        W9   = 3'd3,
        EMIT = 3'd4,
        DROP = 3'd5
    } dec_state_t;

    // len encodes the number of valid bytes in a beat, with 0 meaning all 4.
    function automatic logic beat_is_full(input logic [1:0] len);
        return (len == 2'd0);
    endfunction

endpackage

// File: rtl/st_msg_pkg.sv
// ---------------------------------------------------------------------------
// st_msg_pkg
// Shared message definitions for the st packet encoder/decoder pair.
//   fields_t             : decoded msg3 record (field6..field9 + avail flags)
//   msg_type_supported_t : message type codes carried on st_intf
//   MSG3                 : the only message type this path carries today
//   FIELDx_OFS / FIELDx_W: payload byte offset and bit width of each field
// ---------------------------------------------------------------------------
package st_msg_pkg;

    localparam int MSG_TYPE_W = 2;
    localparam int MSG3_BYTES = 15;

    // Byte offsets inside the serialized msg3 payload
    localparam int FIELD6_OFS = 0;
    localparam int FIELD7_OFS = 4;
    localparam int FIELD8_OFS = 8;
    localparam int FIELD9_OFS = 12;

    // Field widths in bits
    localparam int FIELD6_W = 32;
    localparam int FIELD7_W = 32;
    localparam int FIELD8_W = 32;
    localparam int FIELD9_W = 24;

    typedef enum logic [MSG_TYPE_W-1:0] {
        MSG_NONE = 2'd0,
        MSG1     = 2'd1,
        MSG2     = 2'd2,
        MSG3     = 2'd3
    } msg_type_supported_t;

    typedef struct packed {
        logic [FIELD6_W-1:0] field6;
        logic [FIELD7_W-1:0] field7;
        logic [FIELD8_W-1:0] field8;
        logic [FIELD9_W-1:0] field9;
        logic                field6_avail;
        logic                field7_avail;
        logic                field8_avail;
        logic                field9_avail;
    } fields_t;

endpackage

// File: rtl/st_decoder_if.sv
// ---------------------------------------------------------------------------
// st_pkt_intf : packet beat stream (sop/eop/valid/len/data, ready back)
//   master drives sop, eop, valid, len, data; slave drives ready.
// st_intf     : simple valid/ready handshake carrying a message type
//   master drives data, valid; slave drives ready.
// ---------------------------------------------------------------------------
interface st_pkt_intf #(
    parameter int WIDTH = 32
);
    logic             sop;
    logic             eop;
    logic             valid;
    logic [1:0]       len;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport master (output sop, eop, valid, len, data, input ready);
    modport slave  (input sop, eop, valid, len, data, output ready);
endinterface

interface st_intf #(
    parameter int DW = 2
);
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;

    modport master (output data, valid, input ready);
    modport slave  (input data, valid, output ready);
endinterface

// File: rtl/st_sat_counter.sv
// ---------------------------------------------------------------------------
// st_sat_counter
// Up-counter that sticks at all-ones.
//   clk : clock
//   clr : synchronous clear (highest priority)
//   inc : add one this cycle (ignored once saturated)
//   cnt : current count
// ---------------------------------------------------------------------------
module st_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/st_decoder.sv
// ---------------------------------------------------------------------------
// st_decoder
// Rebuilds a msg3 fields_t record from a 4-beat, 15-byte packet stream and
// announces it with msg type MSG3 on a valid/ready handshake.
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   i_pkt_intf : packet beats in (ready is registered, 0 while emitting)
//   o_msg_type : MSG3 + valid out, ready in
//   o_fields   : decoded fields with per-field avail flags
//   o_err_cnt  : saturating protocol error count (only when the macro
//                ST_DECODER_ERR_CNT_EN is defined)
// ---------------------------------------------------------------------------
module st_decoder
    import st_msg_pkg::*;
    import st_decoder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    st_pkt_intf.slave  i_pkt_intf,
    st_intf.master     o_msg_type,
    output fields_t    o_fields
`ifdef ST_DECODER_ERR_CNT_EN
    ,
    output logic [15:0] o_err_cnt
`endif
);

    dec_state_t          state_q, state_d;
    fields_t             fields_q, fields_d;
    fields_t             fields_restart;
    logic                pkt_ready_q, pkt_ready_d;
    logic                msg_valid_q, msg_valid_d;
    logic [MSG_TYPE_W-1:0] msg_data_q, msg_data_d;
    logic                err_pulse;
    logic                beat_acc;
    logic                beat_full;
    logic [WIDTH-1:0]    beat_data;

    assign beat_acc  = i_pkt_intf.valid && pkt_ready_q;
    assign beat_full = beat_is_full(i_pkt_intf.len);
    assign beat_data = i_pkt_intf.data;

    // Record as it looks after taking the current beat as a fresh field6.
    always_comb begin
        fields_restart = '0;
        if (beat_full) begin
            fields_restart.field6       = beat_data;
            fields_restart.field6_avail = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        fields_d  = fields_q;
        err_pulse = 1'b0;

        // A sop restarts decoding from any collecting state; it is only an
        // error when it cuts off a message already in progress.
        if (beat_acc && i_pkt_intf.sop &&
            (state_q == IDLE || state_q == W7 || state_q == W8 || state_q == W9)) begin
            err_pulse = (state_q != IDLE);
            fields_d  = fields_restart;
            state_d   = i_pkt_intf.eop ? EMIT : W7;
        end else begin
            case (state_q)
                IDLE: begin
                    if (beat_acc) begin
                        err_pulse = 1'b1;
                    end
                end
                W7: begin
                    if (beat_acc) begin
                        if (beat_full) begin
                            fields_d.field7       = beat_data;
                            fields_d.field7_avail = 1'b1;
                        end
                        state_d = i_pkt_intf.eop ? EMIT : W8;
                    end
                end
                W8: begin
                    if (beat_acc) begin
                        if (beat_full) begin
                            fields_d.field8       = beat_data;
                            fields_d.field8_avail = 1'b1;
                        end
                        state_d = i_pkt_intf.eop ? EMIT : W9;
                    end
                end
                W9: begin
                    if (beat_acc) begin
                        if (i_pkt_intf.eop) begin
                            // Only a 3-byte closing beat carries a valid field9.
                            if (i_pkt_intf.len == 2'd3) begin
                                fields_d.field9       = beat_data[23:0];
                                fields_d.field9_avail = 1'b1;
                            end else begin
                                err_pulse = 1'b1;
                            end
                            state_d = EMIT;
                        end else begin
                            err_pulse = 1'b1;
                            state_d   = DROP;
                        end
                    end
                end
                EMIT: begin
                    if (o_msg_type.ready) begin
                        state_d  = IDLE;
                        fields_d = '0;
                    end
                end
                DROP: begin
                    if (beat_acc && i_pkt_intf.eop) begin
                        state_d  = IDLE;
                        fields_d = '0;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    fields_d = '0;
                end
            endcase
        end

        // Outputs are registered from the next state so ready never depends
        // combinationally on valid, and valid rises one cycle after the
        // closing beat.
        pkt_ready_d = (state_d != EMIT);
        msg_valid_d = (state_d == EMIT);
        msg_data_d  = (state_d == EMIT) ? MSG3 : MSG_NONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fields_q    <= '0;
            pkt_ready_q <= 1'b0;
            msg_valid_q <= 1'b0;
            msg_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            fields_q    <= fields_d;
            pkt_ready_q <= pkt_ready_d;
            msg_valid_q <= msg_valid_d;
            msg_data_q  <= msg_data_d;
        end
    end

    assign i_pkt_intf.ready = pkt_ready_q;
    assign o_msg_type.valid = msg_valid_q;
    assign o_msg_type.data  = msg_data_q;
    assign o_fields         = fields_q;

`ifdef ST_DECODER_ERR_CNT_EN
    st_sat_counter #(
        .W (16)
    ) u_err_cnt (
        .clk (clk),
        .clr (~rst_n),
        .inc (err_pulse),
        .cnt (o_err_cnt)
    );
`else
    logic unused_err_pulse;
    assign unused_err_pulse = err_pulse;
`endif

endmodule
